mpf_vtp_port_arbiter: RTL

- Shares one VTP translation service port between N_REQ translation clients, e.g. the read and write channels of an Avalon or CCI-P translate shim.
- Grants requests round-robin and tags each request with the requester index.
- Enforces a per-requester outstanding-request limit.
- Routes translation responses back to the originating requester by tag.

---
 rtl/mpf_vtp_port_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mpf_vtp_port_arbiter.sv
// Round-robin arbiter sharing one VTP translation port among N_REQ clients, with per-client
// outstanding limits and tag-based response routing. Optional counters: MPF_VTP_ARB_STATS_EN.
module mpf_vtp_port_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 48,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_WIDTH       = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_speculative,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [ADDR_WIDTH-1:0]       rsp_addr,
  output logic                        rsp_error,
  output logic                        vtp_req_valid,
  output logic [ADDR_WIDTH-1:0]       vtp_req_addr,
  output logic                        vtp_req_speculative,
  output logic [TAG_WIDTH-1:0]        vtp_req_tag,
  input  logic                        vtp_req_ready,
  input  logic                        vtp_rsp_valid,
  input  logic [TAG_WIDTH-1:0]        vtp_rsp_tag,
  input  logic [ADDR_WIDTH-1:0]       vtp_rsp_addr,
  input  logic                        vtp_rsp_error,
  output logic                        err_bad_tag
`ifdef MPF_VTP_ARB_STATS_EN
  ,
  input  logic                        stats_clear,
  output logic [N_REQ*32-1:0]         stat_grants,
  output logic [31:0]                 stat_stall_cycles
`endif
);

  // Handshake: a request moves when valid && ready on either side; vtp_req_* hold while valid && !ready.
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q [N_REQ];
  logic [CW-1:0]         cnt_d [N_REQ];
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_spec_q, out_spec_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  bad_q, bad_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt_oh;
  logic [N_REQ-1:0] rsp_hit;
  logic [PW-1:0]    gnt_idx;
  logic [PW:0]      rr_sum;
  logic             gnt_found, grant, can_load, rsp_good;

  assign can_load = !out_valid_q || vtp_req_ready;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Scan eligible requesters starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(N_REQ)) rr_sum = rr_sum - (PW+1)'(N_REQ);
      if (!gnt_found && eligible[rr_sum[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_sum[PW-1:0];
      end
    end
  end

  assign grant = gnt_found && can_load;

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = grant && (gnt_idx == PW'(i));
    end
  end

  assign req_ready = reset_n ? gnt_oh : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_spec_d  = out_spec_q;
    out_tag_d   = out_tag_q;
    if (can_load) begin
      out_valid_d = grant;
      if (grant) begin
        out_addr_d = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        out_spec_d = req_speculative[gnt_idx];
        out_tag_d  = TAG_WIDTH'(gnt_idx);
      end
    end
  end

  // A response is only accepted for an in-range tag whose requester has something outstanding.
  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_hit[i] = vtp_rsp_valid && (vtp_rsp_tag == TAG_WIDTH'(i)) && (cnt_q[i] != '0);
    end
  end

  assign rsp_good = |rsp_hit;

  always_comb begin
    rsp_valid_d = rsp_hit;
    rsp_addr_d  = rsp_good ? vtp_rsp_addr  : rsp_addr_q;
    rsp_error_d = rsp_good ? vtp_rsp_error : rsp_error_q;
    bad_d       = bad_q || (vtp_rsp_valid && !rsp_good);
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_oh[i] && !rsp_hit[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!gnt_oh[i] && rsp_hit[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_spec_q  <= 1'b0;
      out_tag_q   <= '0;
      rsp_valid_q <= '0;
      rsp_addr_q  <= '0;
      rsp_error_q <= 1'b0;
      bad_q       <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_spec_q  <= out_spec_d;
      out_tag_q   <= out_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_error_q <= rsp_error_d;
      bad_q       <= bad_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign vtp_req_valid       = out_valid_q;
  assign vtp_req_addr        = out_addr_q;
  assign vtp_req_speculative = out_spec_q;
  assign vtp_req_tag         = out_tag_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_addr            = rsp_addr_q;
  assign rsp_error           = rsp_error_q;
  assign err_bad_tag         = bad_q;

`ifdef MPF_VTP_ARB_STATS_EN
  logic [31:0] grants_q [N_REQ];
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      for (int i = 0; i < N_REQ; i++) grants_q[i] <= '0;
    end else if (stats_clear) begin
      stall_q <= '0;
      for (int i = 0; i < N_REQ; i++) grants_q[i] <= '0;
    end else begin
      if (out_valid_q && !vtp_req_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_oh[i] && (grants_q[i] != '1)) grants_q[i] <= grants_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) stat_grants[i*32 +: 32] = grants_q[i];
  end

  assign stat_stall_cycles = stall_q;
`endif

endmodule
